// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO controller widths and types.
package fifo_pkg;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DEPTH = 2 ** FIFO_ADDR_W;
  typedef logic [FIFO_ADDR_W-1:0] ptr_t;
  typedef logic [FIFO_ADDR_W:0] cnt_t;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer register; ports clk, reset (sync, active-high), inc_i (advance by one), ptr_o (current pointer).
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = FIFO_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_q + W'(inc_i);
  end
  assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO sequencer for a registered-read dual-port RAM.
// Ports: clk, reset (sync, active-high); wr/rd push/pop requests; wr_en/rd_en RAM enables;
// w_addr/r_addr RAM addresses; rd_valid marks r_data holding the popped word; empty/full/count
// occupancy; overflow/underflow sticky rejection flags. Defining FIFO_ALMOST_FLAGS_EN adds the
// ALMOST parameter and the almost_full/almost_empty outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
  , parameter int ALMOST = 2
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  , output logic            almost_full
  , output logic            almost_empty
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic rd_ok, wr_ok, rd_valid_q, empty_q, full_q, overflow_q, underflow_q;
  // Reset gates both enables so nothing reaches the RAM and no rd_valid follows reset.
  assign rd_ok = rd & ~empty_q & ~reset;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign wr_ok = wr & (~full_q | rd_ok) & ~reset;
  always_comb cnt_d = cnt_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      empty_q     <= cnt_d == '0;
      full_q      <= cnt_d == (ADDR_W+1)'(DEPTH);
      rd_valid_q  <= rd_ok;
      overflow_q  <= overflow_q | (wr & ~wr_ok);
      underflow_q <= underflow_q | (rd & ~rd_ok);
    end
  end
`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full_q, almost_empty_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= cnt_d >= (ADDR_W+1)'(DEPTH - ALMOST);
      almost_empty_q <= cnt_d <= (ADDR_W+1)'(ALMOST);
    end
  end
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif
  fifo_ptr #(.W(ADDR_W)) u_wptr (.clk(clk), .reset(reset), .inc_i(wr_ok), .ptr_o(w_addr));
  fifo_ptr #(.W(ADDR_W)) u_rptr (.clk(clk), .reset(reset), .inc_i(rd_ok), .ptr_o(r_addr));
  assign wr_en     = wr_ok;
  assign rd_en     = rd_ok;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = cnt_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencing controller that turns the team's 16x8 dual-port RAM (registered read, 1-cycle latency) into a synchronous FIFO queue.
- Generates write/read addresses and enables from push/pop requests.
- Tracks occupancy; reports full/empty, a read-data-valid strobe, and sticky overflow/underflow errors.
- Sits between the producer/consumer logic and the RAM instance; it holds no data storage itself.

Parameters:
- ADDR_W, 4, address width; FIFO depth DEPTH = 2**ADDR_W = 16 entries.
- ALMOST, 2, threshold for almost flags; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; data is presented to the RAM by the producer in the same cycle.
- rd  input  1  pop request.
- wr_en  output  1  RAM write enable (combinational).
- rd_en  output  1  RAM read enable (combinational).
- w_addr  output  ADDR_W  RAM write address = write pointer.
- r_addr  output  ADDR_W  RAM read address = read pointer.
- rd_valid  output  1  RAM r_data holds the popped word this cycle (registered).
- empty  output  1  occupancy == 0 (registered).
- full  output  1  occupancy == DEPTH (registered).
- count  output  ADDR_W+1  occupancy, 0..DEPTH (registered).
- overflow  output  1  sticky: push rejected because the FIFO was full.
- underflow  output  1  sticky: pop rejected because the FIFO was empty.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - wptr = rptr = 0, count = 0, empty = 1, full = 0.
  - rd_valid = 0, overflow = 0, underflow = 0.
  - wr_en = rd_en = 0 while reset is high, regardless of wr/rd.
- Read acceptance: rd_ok = rd & ~empty; rd_en = rd_ok.
- Write acceptance: wr_ok = wr & (~full | rd_ok); wr_en = wr_ok.
- Push and pop together when full: both accepted, count unchanged. The RAM read returns the old entry (read-before-write) and the write lands in the freed slot.
- Push and pop together when empty: only the push is accepted; the pop is rejected and underflow is set. There is no bypass path.
- Pointers advance by 1 on acceptance and wrap DEPTH-1 -> 0 (natural ADDR_W overflow).
- Occupancy next state, evaluated each cycle:
  - wr_ok only: count+1.
  - rd_ok only: count-1.
  - both or neither: count unchanged.
- empty and full are registered from next-count; count never exceeds DEPTH and never goes below 0.
- rd_valid is rd_ok delayed by exactly 1 cycle, aligned with the RAM's registered r_data. When rd_valid = 0, r_data holds its previous value and is not meaningful.
- overflow is set when wr & ~wr_ok; underflow is set when rd & ~rd_ok. Both hold until reset.
- Reset mid-operation: contents are abandoned. A rd_valid that would have fired in the cycle after reset is suppressed (forced to 0).
- Control states are implied by count, with no separate FSM register: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).

Optional Feature:
- Macro FIFO_ALMOST_FLAGS_EN.
- When defined, two extra registered outputs are added:
  - almost_full = (count >= DEPTH-ALMOST).
  - almost_empty = (count <= ALMOST).
  - Both are 0/1 respectively after reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - localparam FIFO_ADDR_W = 4 and the DEPTH derivation.
  - typedef ptr_t (logic [FIFO_ADDR_W-1:0]) and typedef cnt_t (logic [FIFO_ADDR_W:0]).
- Sub-module fifo_ptr: a wrapping pointer register with synchronous reset and an increment enable. It is instantiated twice, once for write and once for read.
- The RAM is instantiated one level up, in a fifo_top wrapper, not inside fifo_ctrl.

Test Plan:
- Reset, then push 0xFF..0xF0 (16 words) with no pops -> count steps 1..16; full = 1 after the 16th push; w_addr wraps to 0; overflow = 0.
- Push while full (wr = 1, rd = 0) -> wr_en = 0, count stays 16, overflow becomes 1 and stays 1.
- Pop 16 times -> rd_valid pulses 1 cycle after each rd_en; r_data = 0xFF, 0xFE, ..., 0xF0 in order; empty = 1 after the last pop.
- Pop while empty -> rd_en = 0, no rd_valid, underflow = 1.
- Simultaneous push/pop at count = 16 and at count = 5 -> count unchanged; both pointers advance by 1.
- Simultaneous push/pop at count = 0 -> count = 1, underflow = 1.
- Assert reset during a burst with count = 7 and a pop in flight -> next cycle count = 0, empty = 1, rd_valid = 0, both addresses 0.
